mem_responder: RTL and testbench

- Word-organised memory target for the core's multi-cycle fetch/load/store path. The core acts as initiator and this block is the responder.
- Accepts one request at a time over a req/ack handshake.
- Inserts a programmable number of wait states, then performs a read or write on an internal word array and returns data with a single-cycle ack.
- Flags misaligned and out-of-range accesses with err instead of touching the array.

---
 rtl/mem_responder_if.sv | 33 +++
 rtl/mem_responder.sv | 114 +++++++++++
 tb/tb_mem_responder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus between the core (master) and the word memory responder (slave).
// The wstrb lane exists only when MEM_RESPONDER_WSTRB_EN is defined.
interface mem_responder_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
`ifdef MEM_RESPONDER_WSTRB_EN
  logic [3:0]        wstrb;
`endif
  logic [31:0]       rdata;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
`ifdef MEM_RESPONDER_WSTRB_EN
    output wstrb,
`endif
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
`ifdef MEM_RESPONDER_WSTRB_EN
    input  wstrb,
`endif
    output rdata, ack, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word-organised memory responder: accept, programmable wait states, then one-cycle ack.
// Optional byte-lane write strobes are enabled by defining MEM_RESPONDER_WSTRB_EN.
//
// state | meaning
// IDLE  | waiting for req; the accept edge latches the request
// WAIT  | counting down wait states; commit happens when the counter is 0
// RESP  | ack cycle; rdata/err valid, req ignored
module mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 32
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              ack_q;
  logic              err_q;
  logic              busy_q;
`ifdef MEM_RESPONDER_WSTRB_EN
  logic [3:0]        wstrb_q;
`endif

  logic [31:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  addr_bad;
  logic                  commit;
  logic                  do_wr;

  assign idx      = addr_q[DEPTH_LOG2+1:2];
  // Any set bit above the index field means the word address is past the array.
  assign addr_bad = (addr_q[1:0] != 2'b00) || (|addr_q[ADDR_W-1:DEPTH_LOG2+2]);
  assign commit   = (state == WAIT) && (cnt == 4'd0);
  assign do_wr    = commit && we_q && !addr_bad;

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MEM_RESPONDER_WSTRB_EN
      wstrb_q <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= bus.wdata;
`ifdef MEM_RESPONDER_WSTRB_EN
            wstrb_q <= bus.wstrb;
`endif
            cnt     <= 4'(WAIT_STATES);
            busy_q  <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            ack_q   <= 1'b1;
            err_q   <= addr_bad;
            rdata_q <= (addr_bad || we_q) ? 32'd0 : mem[idx];
            state   <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          ack_q  <= 1'b0;
          err_q  <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset; a reset during WAIT drops state to IDLE so do_wr never fires.
  always_ff @(posedge clk) begin
    if (do_wr) begin
`ifdef MEM_RESPONDER_WSTRB_EN
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
`else
      mem[idx] <= wdata_q;
`endif
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized traffic
// checked against an associative-array memory model.
module tb_mem_responder;
  localparam int WS    = 1;
  localparam int DL2   = 10;
  localparam int WORDS = 1 << DL2;

  logic clk;
  logic rst;
  int   tests;
  int   failed;
  int   cyc;

  logic [31:0] model [int];

  mem_responder_if #(.ADDR_W(32)) bus ();

  mem_responder #(
    .DEPTH_LOG2  (DL2),
    .WAIT_STATES (WS),
    .ADDR_W      (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
`ifdef MEM_RESPONDER_WSTRB_EN
    bus.wstrb = s;
`else
    if (s != 4'hF) $display("[TB] note: strobe 0x%0h ignored in full-word build", s);
`endif
  endtask

  function automatic bit is_err(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= WORDS);
  endfunction

  // Full transaction, called at a negedge with the DUT idle; returns at a negedge with DUT idle.
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input string tag);
    logic [31:0] exp_rd;
    logic [31:0] rd_seen;
    bit          exp_err;
    bit          got;
    int          k;
    int          widx;
    exp_err = is_err(a);
    widx    = int'(a / 4);
    exp_rd  = (!exp_err && !w) ? model[widx] : 32'd0;
    bus.req = 1'b1;
    drive(w, a, d, s);
    @(posedge clk);
    @(negedge clk);
    check({tag, " busy after accept"}, 32'(bus.busy), 32'd1);
    // Inputs outside the accept edge must have no effect.
    bus.addr  = $urandom;
    bus.wdata = $urandom;
    bus.we    = ~w;
    got = 1'b0;
    k   = 0;
    while (!got && k < 20) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (bus.ack === 1'b1) got = 1'b1;
    end
    check({tag, " ack seen"}, 32'(got), 32'd1);
    check({tag, " ack latency"}, 32'(k), 32'(WS + 1));
    check({tag, " err"}, 32'(bus.err), 32'(exp_err));
    check({tag, " rdata"}, bus.rdata, exp_rd);
    rd_seen = bus.rdata;
    bus.req = 1'b0;
    @(negedge clk);
    check({tag, " ack drop"}, {29'd0, bus.ack, bus.err, bus.busy}, 32'd0);
    check({tag, " rdata hold"}, bus.rdata, rd_seen);
    if (w && !exp_err) begin
      for (int i = 0; i < 4; i++)
        if (s[i]) model[widx][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  initial begin
    int          e0;
    int          e1;
    int          acks;
    int          first_ack_cnt;
    bit          seen_idle;
    bit          done;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          kind;
    tests  = 0;
    failed = 0;
    rst    = 1'b0;
    bus.req = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 4'hF);

    // Reset held with req asserted: nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset flags %0d", i), {29'd0, bus.ack, bus.err, bus.busy}, 32'd0);
      check($sformatf("reset rdata %0d", i), bus.rdata, 32'd0);
    end
    bus.req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("post-reset idle", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 16; i++) txn(1'b1, 32'(i * 4), $urandom, 4'hF, $sformatf("init w%0d", i));

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr 0x10");
    txn(1'b0, 32'h10, 32'h0, 4'hF, "rd 0x10");
    txn(1'b0, 32'h13, 32'h0, 4'hF, "rd misaligned");
    txn(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, "wr out of range");
    txn(1'b0, 32'h0, 32'h0, 4'hF, "rd 0x0 after bad wr");
    txn(1'b1, 32'hFFC, 32'h0BADCAFE, 4'hF, "wr last word");
    txn(1'b0, 32'hFFC, 32'h0, 4'hF, "rd last word");

    // Sticky req: one ack per accept, next accept WS+3 edges later.
    bus.req = 1'b1;
    drive(1'b0, 32'h10, 32'h0, 4'hF);
    @(posedge clk);
    @(negedge clk);
    e0 = cyc;
    e1 = -1;
    acks = 0;
    first_ack_cnt = 0;
    seen_idle = 1'b0;
    for (int i = 0; i < 20 && e1 < 0; i++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) begin
        acks++;
        check("sticky rdata", bus.rdata, 32'hDEADBEEF);
      end
      if (bus.busy === 1'b0) seen_idle = 1'b1;
      else if (seen_idle) e1 = cyc;
    end
    first_ack_cnt = acks;
    check("sticky acks per accept", 32'(first_ack_cnt), 32'd1);
    check("sticky spacing", 32'(e1 - e0), 32'(WS + 3));
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) begin
        check("sticky 2nd rdata", bus.rdata, 32'hDEADBEEF);
        bus.req = 1'b0;
        done = 1'b1;
      end
    end
    check("sticky 2nd ack seen", 32'(done), 32'd1);
    @(negedge clk);

    // Reset during WAIT aborts the write.
    txn(1'b1, 32'h20, 32'hAAAAAAAA, 4'hF, "wr 0x20 prior");
    bus.req = 1'b1;
    drive(1'b1, 32'h20, 32'h12345678, 4'hF);
    @(posedge clk);
    @(negedge clk);
    check("midop busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    bus.req = 1'b0;
    #1;
    check("midop async clear", {29'd0, bus.ack, bus.err, bus.busy}, 32'd0);
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) acks++;
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) acks++;
    end
    check("midop no ack", 32'(acks), 32'd0);
    txn(1'b0, 32'h20, 32'h0, 4'hF, "rd 0x20 after abort");

`ifdef MEM_RESPONDER_WSTRB_EN
    txn(1'b1, 32'h30, 32'h11223344, 4'hF, "wstrb base");
    txn(1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, "wstrb 0101");
    txn(1'b0, 32'h30, 32'h0, 4'hF, "wstrb rd");
    check("wstrb merged value", model[12], 32'h11BB33DD);
    txn(1'b1, 32'h30, 32'h55555555, 4'b0000, "wstrb none");
    txn(1'b0, 32'h30, 32'h0, 4'b0000, "wstrb none rd");
`endif

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 9);
      d    = $urandom;
      s    = 4'hF;
`ifdef MEM_RESPONDER_WSTRB_EN
      s    = 4'($urandom_range(0, 15));
`endif
      if (kind == 0) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else if (kind == 1) begin
        a = $urandom;
        a = (a | 32'h0000_1000) & 32'hFFFF_FFFC;
      end else a = 32'($urandom_range(0, 15) * 4);
      txn(1'($urandom_range(0, 1)), a, d, s, $sformatf("rand %0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
